atm_pin_entry: RTL and testbench

//  Keypad-side PIN collector/verifier for the ATM controller. Produces the E (entry complete)
//  and V (PIN verified) inputs consumed by the ATM next-state logic, from raw keypad strobes.

---
 rtl/atm_pin_entry.sv | 161 ++++++++++++++++
 tb/tb_atm_pin_entry.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry.sv
// atm_pin_entry
//   Keypad-side PIN collector/verifier. Turns debounced keypad strobes into the
//   E (entry evaluated) and V (PIN verified) inputs of the main ATM FSM, counts
//   wrong attempts and locks the session after MAX_TRIES failures.
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   card_in         card present; low forces IDLE and clears the session
//   key_valid/key_digit, key_enter, key_clear   one-cycle keypad strobes
//   session_done    main FSM finished the transaction (leaves PASS)
//   pin_ref         stored PIN, MS digit in top nibble, sampled in CHECK
//   pin_e           1-cycle pulse in the first cycle after CHECK
//   pin_v           high while in PASS
//   lockout         high while in LOCK
//   timeout         1-cycle pulse when COLLECT times out
//   tries           wrong attempts this session (saturating)
//   digit_cnt       digits currently buffered
module atm_pin_entry #(
  parameter int PIN_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             card_in,
  input  logic                             key_valid,
  input  logic [3:0]                       key_digit,
  input  logic                             key_enter,
  input  logic                             key_clear,
  input  logic                             session_done,
  input  logic [4*PIN_DIGITS-1:0]          pin_ref,
  output logic                             pin_e,
  output logic                             pin_v,
  output logic                             lockout,
  output logic                             timeout,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
  output logic [$clog2(PIN_DIGITS+1)-1:0]  digit_cnt
);
  localparam int BW = 4*PIN_DIGITS;
  localparam int TW = $clog2(MAX_TRIES+1);
  localparam int CW = $clog2(PIN_DIGITS+1);
  localparam int IW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_CHECK, S_FAIL, S_PASS, S_LOCK
  } state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   buf_q, buf_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [TW-1:0]   tries_q, tries_n;
  logic [IW-1:0]   idle_q, idle_n;
  // Set by a timeout: the card must be pulled and reinserted before a new
  // session may start, otherwise IDLE would re-enter COLLECT immediately.
  logic            hold_q, hold_n;
  logic            e_n, to_n;
  logic            any_key;

  assign any_key = key_valid | key_enter | key_clear;

  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    tries_n = tries_q;
    idle_n  = idle_q;
    hold_n  = hold_q;
    e_n     = 1'b0;
    to_n    = 1'b0;
    if (!card_in) begin
      state_n = S_IDLE;
      buf_n   = '0;
      cnt_n   = '0;
      tries_n = '0;
      idle_n  = '0;
      hold_n  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (!hold_q) begin
          state_n = S_COLLECT;
          buf_n   = '0;
          cnt_n   = '0;
          tries_n = '0;
          idle_n  = '0;
        end
        S_COLLECT: begin
          if (key_clear) begin
            buf_n = '0;
            cnt_n = '0;
          end else if (key_enter) begin
            if (cnt_q == CW'(PIN_DIGITS)) state_n = S_CHECK;
          end else if (key_valid && key_digit <= 4'd9 && cnt_q < CW'(PIN_DIGITS)) begin
            buf_n = (buf_q << 4) | BW'(key_digit);
            cnt_n = cnt_q + CW'(1);
          end
          // Any strobe, even an ignored one, counts as activity.
          if (any_key) begin
            idle_n = '0;
          end else if (idle_q == IW'(TIMEOUT_CYC-1)) begin
            to_n    = 1'b1;
            state_n = S_IDLE;
            buf_n   = '0;
            cnt_n   = '0;
            tries_n = '0;
            idle_n  = '0;
            hold_n  = 1'b1;
          end else begin
            idle_n = idle_q + IW'(1);
          end
        end
        S_CHECK: begin
          e_n = 1'b1;
          if (buf_q == pin_ref) begin
            state_n = S_PASS;
          end else begin
            if (tries_q < TW'(MAX_TRIES)) tries_n = tries_q + TW'(1);
            state_n = (tries_q + TW'(1) >= TW'(MAX_TRIES)) ? S_LOCK : S_FAIL;
          end
        end
        S_FAIL: begin
          state_n = S_COLLECT;
          buf_n   = '0;
          cnt_n   = '0;
          idle_n  = '0;
        end
        S_PASS:  if (session_done) state_n = S_IDLE;
        S_LOCK:  state_n = S_LOCK;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      idle_q  <= '0;
      hold_q  <= 1'b0;
      pin_e   <= 1'b0;
      pin_v   <= 1'b0;
      lockout <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      tries_q <= tries_n;
      idle_q  <= idle_n;
      hold_q  <= hold_n;
      pin_e   <= e_n;
      pin_v   <= (state_n == S_PASS);
      lockout <= (state_n == S_LOCK);
      timeout <= to_n;
    end
  end

  assign tries     = tries_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry (PIN_DIGITS=4, MAX_TRIES=3, TIMEOUT_CYC=20).
module tb_atm_pin_entry;
  localparam int PD = 4;
  localparam int MT = 3;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n, card_in, key_valid, key_enter, key_clear, session_done;
  logic [3:0]  key_digit;
  logic [15:0] pin_ref;
  logic        pin_e, pin_v, lockout, timeout;
  logic [1:0]  tries;
  logic [2:0]  digit_cnt;

  int ncmp = 0;
  int nerr = 0;
  int n, cnt_to;

  atm_pin_entry #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .key_valid(key_valid),
    .key_digit(key_digit), .key_enter(key_enter), .key_clear(key_clear),
    .session_done(session_done), .pin_ref(pin_ref), .pin_e(pin_e),
    .pin_v(pin_v), .lockout(lockout), .timeout(timeout), .tries(tries),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic pin4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    rst_n = 1'b0; card_in = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    key_enter = 1'b0; key_clear = 1'b0; session_done = 1'b0; pin_ref = 16'h1234;
    tick(); tick();
    chk("rst pin_e", pin_e, 0);
    chk("rst pin_v", pin_v, 0);
    chk("rst lockout", lockout, 0);
    chk("rst timeout", timeout, 0);
    chk("rst tries", tries, 0);
    chk("rst digit_cnt", digit_cnt, 0);
    rst_n = 1'b1;
    tick();

    // 1) correct PIN
    card_in = 1'b1; tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t1 digit_cnt", digit_cnt, 4);
    enter();
    chk("t1 pin_e in CHECK", pin_e, 0);
    tick();
    chk("t1 pin_e pulse", pin_e, 1);
    chk("t1 pin_v", pin_v, 1);
    chk("t1 tries", tries, 0);
    press(4'd5);
    chk("t1 pin_e one cycle", pin_e, 0);
    chk("t1 pin_v held", pin_v, 1);
    chk("t1 key in PASS", digit_cnt, 4);
    session_done = 1'b1; tick(); session_done = 1'b0;
    chk("t1 pin_v after done", pin_v, 0);
    card_in = 1'b0; tick();

    // 2) three wrong PINs -> lock
    card_in = 1'b1; tick();
    for (int k = 1; k <= 3; k++) begin
      pin4(4'd1, 4'd2, 4'd3, 4'd5);
      enter();
      tick();
      chk("t2 pin_e", pin_e, 1);
      chk("t2 tries", tries, k);
      chk("t2 pin_v", pin_v, 0);
      if (k < 3) begin
        chk("t2 lockout low", lockout, 0);
        tick();
        chk("t2 cnt after FAIL", digit_cnt, 0);
      end else begin
        chk("t2 lockout high", lockout, 1);
      end
    end
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    enter(); tick();
    session_done = 1'b1; tick(); session_done = 1'b0;
    chk("t2 lock keys ignored", digit_cnt, 4);
    chk("t2 lock no pin_e", pin_e, 0);
    chk("t2 lock held", lockout, 1);
    chk("t2 tries saturated", tries, 3);
    card_in = 1'b0; tick();
    chk("t2 unlock", lockout, 0);
    chk("t2 tries cleared", tries, 0);
    chk("t2 cnt cleared", digit_cnt, 0);

    // 3) early enter, invalid digit, overflow digit
    card_in = 1'b1; tick();
    press(4'd1); press(4'd2); press(4'd3);
    enter();
    chk("t3 early enter pin_e", pin_e, 0);
    tick();
    chk("t3 early enter no check", pin_e, 0);
    chk("t3 cnt 3", digit_cnt, 3);
    press(4'hA);
    chk("t3 digit A ignored", digit_cnt, 3);
    press(4'd4);
    chk("t3 cnt 4", digit_cnt, 4);
    press(4'd7);
    chk("t3 full ignored", digit_cnt, 4);
    enter(); tick();
    chk("t3 pin_e", pin_e, 1);
    chk("t3 pin_v", pin_v, 1);
    card_in = 1'b0; tick();
    chk("t3 card out pin_v", pin_v, 0);

    // 4) clear beats digit in same cycle
    card_in = 1'b1; tick();
    press(4'd9); press(4'd9);
    chk("t4 cnt 2", digit_cnt, 2);
    key_clear = 1'b1; key_valid = 1'b1; key_digit = 4'd5;
    tick();
    key_clear = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    chk("t4 clear wins", digit_cnt, 0);
    pin4(4'd1, 4'd2, 4'd3, 4'd4);
    enter(); tick();
    chk("t4 pin after clear", pin_v, 1);
    card_in = 1'b0; tick();

    // 5) timeout, tries cleared, no restart until reinsertion
    card_in = 1'b1; tick();
    pin4(4'd1, 4'd2, 4'd3, 4'd5);
    enter(); tick(); tick();
    chk("t5 tries before timeout", tries, 1);
    n = 0;
    do begin tick(); n++; end while (!timeout && n < 200);
    chk("t5 timeout cycles", n, TO);
    chk("t5 timeout seen", timeout, 1);
    chk("t5 tries cleared", tries, 0);
    cnt_to = 0;
    for (int i = 0; i < TO + 10; i++) begin
      tick();
      if (timeout) cnt_to++;
    end
    chk("t5 single pulse", cnt_to, 0);
    press(4'd1);
    chk("t5 key ignored in IDLE", digit_cnt, 0);
    card_in = 1'b0; tick();
    card_in = 1'b1; tick();
    press(4'd1);
    chk("t5 restart", digit_cnt, 1);
    for (int i = 0; i < 14; i++) tick();
    press(4'hA);
    n = 0;
    do begin tick(); n++; end while (!timeout && n < 200);
    chk("t5 ignored key resets idle", n, TO);
    card_in = 1'b0; tick();

    // 6) card pulled mid-entry; reset mid-entry
    card_in = 1'b1; tick();
    press(4'd1); press(4'd2); press(4'd3);
    chk("t6 cnt 3", digit_cnt, 3);
    card_in = 1'b0; tick();
    chk("t6 cnt cleared", digit_cnt, 0);
    chk("t6 no pin_e", pin_e, 0);
    tick();
    chk("t6 no pin_e later", pin_e, 0);
    card_in = 1'b1; tick();
    press(4'd7); press(4'd8);
    #2 rst_n = 1'b0; #1;
    chk("t6 async reset cnt", digit_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6 reset no pin_e", pin_e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
